// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl: the Z80 side of the VDP.
//  - Decodes IN/OUT cycles on port 0xBE (data) and port 0xBF (control/status).
//    A port hits when addr[7:6]==2'b10; addr[0] selects data (0) or control (1).
//  - Holds the two-byte command latch, the auto-incrementing VRAM address,
//    the read-ahead buffer, and issues register and CRAM write pulses.
//  - Shares the single VRAM port with the render engine. A CPU access waits
//    at most STARVE_MAX cycles for the renderer.
//  - Keeps the frame, sprite-overflow and sprite-collision status flags and
//    drives INT_L.
// Ports:
//   clk_25, rst                         clock, asynchronous active-high reset
//   IORQ_L, RD_L, WR_L                  Z80 strobes (asynchronous, active low)
//   addr_bus_in, data_bus_in            Z80 port address and write data
//   data_bus_out, data_oe               Z80 read data and its output enable
//   ren_req, ren_addr, ren_grant        render engine VRAM request/grant
//   vram_en, vram_we, vram_addr,
//   vram_wdata, vram_rdata              VRAM port (read data one cycle late)
//   cram_we, cram_addr, cram_wdata      CRAM write
//   reg_we, reg_addr, reg_wdata         VDP register write
//   frame_irq, spr_ovf, spr_coll        event pulses from the render engine
//   irq_en                              frame interrupt enable
//   INT_L                               Z80 interrupt, active low
//   cpu_busy                            a CPU VRAM access is in flight
module vdp_port_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int STARVE_MAX  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              IORQ_L,
  input  logic              RD_L,
  input  logic              WR_L,
  input  logic [7:0]        addr_bus_in,
  input  logic [7:0]        data_bus_in,
  output logic [7:0]        data_bus_out,
  output logic              data_oe,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_grant,
  output logic              vram_en,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic              cram_we,
  output logic [4:0]        cram_addr,
  output logic [7:0]        cram_wdata,
  output logic              reg_we,
  output logic [3:0]        reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic              frame_irq,
  input  logic              spr_ovf,
  input  logic              spr_coll,
  input  logic              irq_en,
  output logic              INT_L,
  output logic              cpu_busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CPU_WAIT = 2'd1;
  localparam logic [1:0] CPU_ACC  = 2'd2;
  localparam logic [1:0] RD_CAP   = 2'd3;

  // Strobe synchronisers and edge detect
  logic [SYNC_STAGES-1:0] iorq_sync, rd_sync, wr_sync;
  logic wr_n, rd_n, wr_n_q, rd_n_q;
  logic wr_ev, rd_ev;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      iorq_sync <= '1;
      rd_sync   <= '1;
      wr_sync   <= '1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
    end else begin
      iorq_sync[0] <= IORQ_L;
      rd_sync[0]   <= RD_L;
      wr_sync[0]   <= WR_L;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        iorq_sync[i] <= iorq_sync[i-1];
        rd_sync[i]   <= rd_sync[i-1];
        wr_sync[i]   <= wr_sync[i-1];
      end
      wr_n_q <= wr_n;
      rd_n_q <= rd_n;
    end
  end

  assign wr_n  = iorq_sync[SYNC_STAGES-1] | wr_sync[SYNC_STAGES-1];
  assign rd_n  = iorq_sync[SYNC_STAGES-1] | rd_sync[SYNC_STAGES-1];
  // One event per Z80 cycle: only the falling edge of the combined strobe.
  // The address and data buses are stable long before the synchronised edge.
  assign wr_ev = wr_n_q & ~wr_n;
  assign rd_ev = rd_n_q & ~rd_n;

  logic hit;
  logic wr_data_ev, wr_ctrl_ev, rd_data_ev, rd_ctrl_ev;

  assign hit        = (addr_bus_in[7:6] == 2'b10);
  assign wr_data_ev = wr_ev & hit & ~addr_bus_in[0];
  assign wr_ctrl_ev = wr_ev & hit &  addr_bus_in[0];
  assign rd_data_ev = rd_ev & hit & ~addr_bus_in[0];
  assign rd_ctrl_ev = rd_ev & hit &  addr_bus_in[0];

  // Only the decode bits and the port select bit matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_bus_in[5:1];

  assign data_oe = ~IORQ_L & ~RD_L & hit;

  // Command latch, address counter and the CPU access it generates
  logic [ADDR_W-1:0] addr, ctrl_addr;
  logic [1:0]        code;
  logic              first_byte;
  logic [7:0]        rd_buf;
  logic              int_flag, ovf_flag, coll_flag;

  logic              acc_vld, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]        acc_wdata;

  // Address formed by the second control byte.
  assign ctrl_addr = ADDR_W'({data_bus_in[5:0], addr[7:0]});

  always_comb begin
    acc_vld   = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = addr;
    acc_wdata = data_bus_in;
    if (wr_data_ev && code != 2'b11) begin
      acc_vld = 1'b1;
      acc_we  = 1'b1;
    end else if (rd_data_ev) begin
      acc_vld = 1'b1;
    end else if (wr_ctrl_ev && !first_byte && data_bus_in[7:6] == 2'b00) begin
      acc_vld  = 1'b1;
      acc_addr = ctrl_addr;
    end
  end

  logic [1:0] state;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      addr         <= '0;
      code         <= 2'b00;
      first_byte   <= 1'b1;
      rd_buf       <= 8'h00;
      data_bus_out <= 8'h00;
      int_flag     <= 1'b0;
      ovf_flag     <= 1'b0;
      coll_flag    <= 1'b0;
      reg_we       <= 1'b0;
      reg_addr     <= 4'h0;
      reg_wdata    <= 8'h00;
      cram_we      <= 1'b0;
      cram_addr    <= 5'h00;
      cram_wdata   <= 8'h00;
    end else begin
      reg_we  <= 1'b0;
      cram_we <= 1'b0;

      if (wr_ctrl_ev) begin
        if (first_byte) begin
          addr       <= {addr[ADDR_W-1:8], data_bus_in};
          first_byte <= 1'b0;
        end else begin
          code       <= data_bus_in[7:6];
          first_byte <= 1'b1;
          // A code-00 prefetch consumes the new address, so it advances too.
          addr       <= (data_bus_in[7:6] == 2'b00) ? ctrl_addr + ADDR_W'(1) : ctrl_addr;
          if (data_bus_in[7:6] == 2'b10) begin
            reg_we    <= 1'b1;
            reg_addr  <= data_bus_in[3:0];
            reg_wdata <= addr[7:0];
          end
        end
      end

      if (wr_data_ev) begin
        first_byte <= 1'b1;
        addr       <= addr + ADDR_W'(1);
        if (code == 2'b11) begin
          cram_we    <= 1'b1;
          cram_addr  <= addr[4:0];
          cram_wdata <= data_bus_in;
        end
      end

      if (rd_data_ev) begin
        first_byte   <= 1'b1;
        addr         <= addr + ADDR_W'(1);
        data_bus_out <= rd_buf;
      end

      if (rd_ctrl_ev) begin
        first_byte   <= 1'b1;
        data_bus_out <= {int_flag, ovf_flag, coll_flag, 5'b0};
      end

      // A write refreshes the buffer after any read capture in the same cycle.
      if (state == RD_CAP) rd_buf <= vram_rdata;
      if (wr_data_ev)      rd_buf <= data_bus_in;

      // A new event pulse beats a simultaneous status-read clear.
      int_flag  <= frame_irq | (int_flag  & ~rd_ctrl_ev);
      ovf_flag  <= spr_ovf   | (ovf_flag  & ~rd_ctrl_ev);
      coll_flag <= spr_coll  | (coll_flag & ~rd_ctrl_ev);
    end
  end

  assign INT_L = ~(int_flag & irq_en);

  // VRAM arbiter: one access in flight plus a one-deep hold slot
  logic [SW-1:0]     starve;
  logic              cur_we, hold_vld, hold_we;
  logic [ADDR_W-1:0] cur_addr, hold_addr;
  logic [7:0]        cur_wdata, hold_wdata;

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve     <= '0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= 8'h00;
      hold_vld   <= 1'b0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= 8'h00;
    end else begin
      if (acc_vld && (state != IDLE || hold_vld)) begin
        hold_vld   <= 1'b1;
        hold_we    <= acc_we;
        hold_addr  <= acc_addr;
        hold_wdata <= acc_wdata;
      end
      case (state)
        IDLE: begin
          if (hold_vld) begin
            cur_we    <= hold_we;
            cur_addr  <= hold_addr;
            cur_wdata <= hold_wdata;
            hold_vld  <= acc_vld;
            state     <= CPU_WAIT;
          end else if (acc_vld) begin
            cur_we    <= acc_we;
            cur_addr  <= acc_addr;
            cur_wdata <= acc_wdata;
            state     <= CPU_WAIT;
          end
        end
        CPU_WAIT: begin
          if (!ren_req || starve == SW'(STARVE_MAX - 1)) begin
            starve <= '0;
            state  <= CPU_ACC;
          end else begin
            starve <= starve + SW'(1);
          end
        end
        CPU_ACC: state <= cur_we ? IDLE : RD_CAP;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_busy = (state != IDLE);

  always_comb begin
    vram_en    = 1'b0;
    vram_we    = 1'b0;
    vram_addr  = ren_addr;
    vram_wdata = cur_wdata;
    ren_grant  = 1'b0;
    if (state == CPU_ACC) begin
      vram_en   = 1'b1;
      vram_we   = cur_we;
      vram_addr = cur_addr;
    end else if (ren_req) begin
      vram_en   = 1'b1;
      ren_grant = 1'b1;
    end
  end

endmodule
